// File: rtl/tetris_input_ctrl_if.sv
// Input-conditioning bus for tetris_input_ctrl: raw joystick/button inputs,
// the game_over gate from the grid core, and the four clean move levels.
interface tetris_input_ctrl_if #(
  parameter int ADC_W = 12
);
  logic [ADC_W-1:0] adc_value;
  logic             adc_valid;
  logic             key_rotate_n;
  logic             key_drop_n;
  logic             game_over;
  logic             move_left;
  logic             move_right;
  logic             move_down;
  logic             rotate;

  // Producer side: drives raw inputs, consumes the move levels.
  modport master (
    output adc_value, adc_valid, key_rotate_n, key_drop_n, game_over,
    input  move_left, move_right, move_down, rotate
  );

  // Conditioning block side.
  modport slave (
    input  adc_value, adc_valid, key_rotate_n, key_drop_n, game_over,
    output move_left, move_right, move_down, rotate
  );
endinterface

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: conditions the joystick ADC sample and the two raw
// push-buttons into clean move_left/move_right/move_down/rotate levels.
//  - buttons: 2-flop synchroniser plus counter debounce (DEBOUNCE_CYC cycles)
//  - joystick: hysteretic CENTER/LEFT/RIGHT FSM, advanced only on adc_valid
//  - all outputs gated low while game_over is high
// Optional build macro TETRIS_INPUT_ADC_WATCHDOG_EN: forces the joystick back
// to CENTER when no adc_valid has arrived for STALE_CYC cycles.
module tetris_input_ctrl #(
  parameter int ADC_W        = 12,
  parameter int LEFT_TH      = 1024,
  parameter int RIGHT_TH     = 3072,
  parameter int HYST         = 128,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int STALE_CYC    = 5_000_000
) (
  input logic               clk,
  input logic               reset_n,
  tetris_input_ctrl_if.slave ctrl
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  // Thresholds widened by one bit so LEFT_TH+HYST cannot wrap.
  localparam logic [ADC_W:0] LEFT_LO  = (ADC_W+1)'(LEFT_TH);
  localparam logic [ADC_W:0] LEFT_HI  = (ADC_W+1)'(LEFT_TH + HYST);
  localparam logic [ADC_W:0] RIGHT_HI = (ADC_W+1)'(RIGHT_TH);
  localparam logic [ADC_W:0] RIGHT_LO = (ADC_W+1)'(RIGHT_TH - HYST);

  typedef enum logic [1:0] {
    JOY_CENTER = 2'd0,
    JOY_LEFT   = 2'd1,
    JOY_RIGHT  = 2'd2
  } joy_state_t;

  // Bit 0 = rotate key, bit 1 = drop key; both active-low, 1 = released.
  logic [1:0]      key_raw;
  logic [1:0]      key_p0;
  logic [1:0]      key_p1;
  logic [1:0]      key_stable;
  logic [DB_W-1:0] db_cnt [2];

  joy_state_t      joy_state;
  joy_state_t      joy_next;
  logic [ADC_W:0]  adc_x;
  logic            stale;

  logic            left_q;
  logic            right_q;
  logic            down_q;
  logic            rot_q;

  assign key_raw = {ctrl.key_drop_n, ctrl.key_rotate_n};
  assign adc_x   = {1'b0, ctrl.adc_value};

  // Synchronise both keys and accept a change only after it has held for
  // DEBOUNCE_CYC consecutive cycles; any return to the stable level restarts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_p0     <= 2'b11;
      key_p1     <= 2'b11;
      key_stable <= 2'b11;
      db_cnt[0]  <= '0;
      db_cnt[1]  <= '0;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
      for (int k = 0; k < 2; k++) begin
        if (key_p1[k] == key_stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
          key_stable[k] <= key_p1[k];
          db_cnt[k]     <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

`ifdef TETRIS_INPUT_ADC_WATCHDOG_EN
  localparam int WD_W = $clog2(STALE_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  assign stale = (wd_cnt == WD_W'(STALE_CYC - 1));

  // Cycles since the last ADC sample; saturates at the timeout value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (ctrl.adc_valid) begin
      wd_cnt <= '0;
    end else if (!stale) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog the joystick state never goes stale; STALE_CYC is
  // kept only so both builds share one parameter list.
  assign stale = 1'b0 & (STALE_CYC != 0);
`endif

  // Joystick state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy_state <= JOY_CENTER;
    end else begin
      joy_state <= joy_next;
    end
  end

  // Hysteretic next-state: enter LEFT/RIGHT at the thresholds, return to
  // CENTER only once the sample is HYST inside; a fresh sample beats timeout.
  always_comb begin
    joy_next = joy_state;
    if (ctrl.adc_valid) begin
      unique case (joy_state)
        JOY_CENTER: begin
          if (adc_x < LEFT_LO)       joy_next = JOY_LEFT;
          else if (adc_x > RIGHT_HI) joy_next = JOY_RIGHT;
        end
        JOY_LEFT: begin
          if (adc_x > RIGHT_HI)      joy_next = JOY_RIGHT;
          else if (adc_x >= LEFT_HI) joy_next = JOY_CENTER;
        end
        JOY_RIGHT: begin
          if (adc_x < LEFT_LO)        joy_next = JOY_LEFT;
          else if (adc_x <= RIGHT_LO) joy_next = JOY_CENTER;
        end
        default: joy_next = JOY_CENTER;
      endcase
    end else if (stale) begin
      joy_next = JOY_CENTER;
    end
  end

  // Registered, game_over-gated output levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      down_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      left_q  <= (joy_state == JOY_LEFT)  & ~ctrl.game_over;
      right_q <= (joy_state == JOY_RIGHT) & ~ctrl.game_over;
      down_q  <= ~key_stable[1] & ~ctrl.game_over;
      rot_q   <= ~key_stable[0] & ~ctrl.game_over;
    end
  end

  assign ctrl.move_left  = left_q;
  assign ctrl.move_right = right_q;
  assign ctrl.move_down  = down_q;
  assign ctrl.rotate     = rot_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Testbench for tetris_input_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the key and joystick rules.
module tb_tetris_input_ctrl;

  localparam int ADC_W    = 12;
  localparam int LEFT_TH  = 1024;
  localparam int RIGHT_TH = 3072;
  localparam int HYST     = 128;
  localparam int DB       = 8;
  localparam int STALE    = 32;

  logic clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  tetris_input_ctrl_if #(.ADC_W(ADC_W)) bus ();

  tetris_input_ctrl #(
    .ADC_W(ADC_W), .LEFT_TH(LEFT_TH), .RIGHT_TH(RIGHT_TH), .HYST(HYST),
    .DEBOUNCE_CYC(DB), .STALE_CYC(STALE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctrl(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // joy: 0 = centre, 1 = left, 2 = right
  int  joy;
  int  since_valid;
  bit  st_rot, st_drop;
  bit  q_rot[$];
  bit  q_drop[$];
  bit  exp_left, exp_right, exp_down, exp_rot;
  bit  model_ok = 0;

  // A key's accepted level flips once the synchronised input has shown the
  // opposite level for each of the last DB cycles. The queue holds the last
  // DB+1 raw samples; the newest two are still inside the synchroniser.
  function automatic bit settle(bit q[$], bit st);
    for (int i = 0; i < DB; i++)
      if (q[i] == st) return st;
    return !st;
  endfunction

  function automatic int joy_step(int s, int v);
    case (s)
      0: if (v < LEFT_TH) return 1; else if (v > RIGHT_TH) return 2;
      1: if (v > RIGHT_TH) return 2; else if (v >= LEFT_TH + HYST) return 0;
      default: if (v < LEFT_TH) return 1; else if (v <= RIGHT_TH - HYST) return 0;
    endcase
    return s;
  endfunction

  always @(posedge clk) begin
    bit nl, nr, nd, nrot;
    bit wd_en;
`ifdef TETRIS_INPUT_ADC_WATCHDOG_EN
    wd_en = 1'b1;
`else
    wd_en = 1'b0;
`endif
    if (!reset_n) begin
      joy = 0; since_valid = 0; st_rot = 1; st_drop = 1;
      q_rot = {}; q_drop = {};
      for (int i = 0; i < DB + 1; i++) begin
        q_rot.push_back(1'b1);
        q_drop.push_back(1'b1);
      end
      exp_left = 0; exp_right = 0; exp_down = 0; exp_rot = 0;
    end else begin
      nl   = (joy == 1) && !bus.game_over;
      nr   = (joy == 2) && !bus.game_over;
      nd   = !st_drop && !bus.game_over;
      nrot = !st_rot && !bus.game_over;
      st_rot  = settle(q_rot, st_rot);
      st_drop = settle(q_drop, st_drop);
      q_rot.push_back(bus.key_rotate_n);   void'(q_rot.pop_front());
      q_drop.push_back(bus.key_drop_n);    void'(q_drop.pop_front());
      if (bus.adc_valid) begin
        joy = joy_step(joy, int'(bus.adc_value));
        since_valid = 0;
      end else begin
        if (wd_en && since_valid >= STALE - 1) joy = 0;
        since_valid++;
      end
      exp_left = nl; exp_right = nr; exp_down = nd; exp_rot = nrot;
    end
    model_ok = 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_move_left",  bus.move_left,  exp_left);
      chk("model_move_right", bus.move_right, exp_right);
      chk("model_move_down",  bus.move_down,  exp_down);
      chk("model_rotate",     bus.rotate,     exp_rot);
      chk("left_right_exclusive", bus.move_left & bus.move_right, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic adc_step(input int v, input logic el, input logic er, input string name);
    bus.adc_value = ADC_W'(v);
    bus.adc_valid = 1'b1;
    cyc(1);
    bus.adc_valid = 1'b0;
    cyc(1);
    chk({name, "_left"},  bus.move_left,  el);
    chk({name, "_right"}, bus.move_right, er);
  endtask

  function automatic int pick_adc();
    case ($urandom_range(0, 15))
      0: return 1023;  1: return 1024;  2: return 1025;
      3: return 1151;  4: return 1152;  5: return 1153;
      6: return 2943;  7: return 2944;  8: return 2945;
      9: return 3071; 10: return 3072; 11: return 3073;
      12: return 0;   13: return 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    reset_n          = 1'b0;
    bus.adc_value    = '0;
    bus.adc_valid    = 1'b0;
    bus.key_rotate_n = 1'b0;
    bus.key_drop_n   = 1'b0;
    bus.game_over    = 1'b0;

    // Reset with both keys held low.
    cyc(3);
    chk("rst_left",  bus.move_left,  1'b0);
    chk("rst_right", bus.move_right, 1'b0);
    chk("rst_down",  bus.move_down,  1'b0);
    chk("rst_rotate", bus.rotate,    1'b0);
    reset_n = 1'b1;
    cyc(10);
    chk("rst_rotate_c10", bus.rotate, 1'b0);
    cyc(1);
    chk("rst_rotate_c11", bus.rotate, 1'b1);
    chk("rst_down_c11",   bus.move_down, 1'b1);

    // Release, then a clean drop press and release.
    bus.key_rotate_n = 1'b1;
    bus.key_drop_n   = 1'b1;
    cyc(12);
    chk("release_rotate", bus.rotate, 1'b0);
    bus.key_drop_n = 1'b0;
    cyc(10);
    chk("drop_c10", bus.move_down, 1'b0);
    cyc(1);
    chk("drop_c11", bus.move_down, 1'b1);
    bus.key_drop_n = 1'b1;
    cyc(10);
    chk("drop_rel_c10", bus.move_down, 1'b1);
    cyc(1);
    chk("drop_rel_c11", bus.move_down, 1'b0);

    // Five-cycle glitch must be rejected.
    bus.key_drop_n = 1'b0;
    cyc(5);
    bus.key_drop_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("glitch_down", bus.move_down, 1'b0);
    end

    // Joystick hysteresis, boundaries and direct swings.
    adc_step(2048, 1'b0, 1'b0, "adc2048");
    adc_step(900,  1'b1, 1'b0, "adc900");
    adc_step(1100, 1'b1, 1'b0, "adc1100");
    adc_step(1151, 1'b1, 1'b0, "adc1151");
    adc_step(1152, 1'b0, 1'b0, "adc1152");
    adc_step(3073, 1'b0, 1'b1, "adc3073");
    adc_step(2945, 1'b0, 1'b1, "adc2945");
    adc_step(2944, 1'b0, 1'b0, "adc2944");
    adc_step(3000, 1'b0, 1'b0, "adc3000");
    adc_step(1024, 1'b0, 1'b0, "adc1024_edge");
    adc_step(3072, 1'b0, 1'b0, "adc3072_edge");
    adc_step(1023, 1'b1, 1'b0, "adc1023");
    adc_step(4000, 1'b0, 1'b1, "swing_to_right");
    adc_step(0,    1'b1, 1'b0, "swing_to_left");
    adc_step(4095, 1'b0, 1'b1, "adc4095");
    adc_step(900,  1'b1, 1'b0, "back_left");

    // game_over gating with keys held and joystick left.
    bus.key_rotate_n = 1'b0;
    bus.key_drop_n   = 1'b0;
    cyc(12);
    chk("go_pre_rotate", bus.rotate, 1'b1);
    chk("go_pre_down",   bus.move_down, 1'b1);
    chk("go_pre_left",   bus.move_left, 1'b1);
    bus.game_over = 1'b1;
    cyc(1);
    chk("go_rotate", bus.rotate, 1'b0);
    chk("go_down",   bus.move_down, 1'b0);
    chk("go_left",   bus.move_left, 1'b0);
    cyc(3);
    bus.game_over = 1'b0;
    cyc(1);
    chk("go_end_rotate", bus.rotate, 1'b1);
    chk("go_end_down",   bus.move_down, 1'b1);
    chk("go_end_left",   bus.move_left, 1'b1);
    bus.key_rotate_n = 1'b1;
    bus.key_drop_n   = 1'b1;

    // Long gap without samples while RIGHT.
    adc_step(3500, 1'b0, 1'b1, "wd_enter_right");
    cyc(40);
`ifdef TETRIS_INPUT_ADC_WATCHDOG_EN
    chk("wd_timeout_right", bus.move_right, 1'b0);
`else
    chk("wd_hold_right", bus.move_right, 1'b1);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 5000; i++) begin
      bus.adc_valid = ($urandom_range(0, 2) == 0);
      bus.adc_value = ADC_W'(pick_adc());
      if ($urandom_range(0, 11) == 0) bus.key_rotate_n = ~bus.key_rotate_n;
      if ($urandom_range(0, 11) == 0) bus.key_drop_n   = ~bus.key_drop_n;
      if ($urandom_range(0, 39) == 0) bus.game_over    = ~bus.game_over;
      reset_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 299) == 0) begin
        bus.adc_valid = 1'b0;
        cyc(36);
      end
      cyc(1);
    end
    reset_n = 1'b1;
    bus.adc_valid = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
